// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte sources.
// state       | meaning
// S_IDLE      | scanning requesters, req_ready offered to the winner
// S_ISSUE     | tx_start pulse for the accepted byte
// S_WAIT_BUSY | waiting for the transmitter to raise busy, with timeout
// S_WAIT_DONE | frame in progress, waiting for busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_arb_busy,
  output logic                          o_err_timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam int TOW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t                r_state;
  logic [IDW-1:0]        r_rr_ptr;
  logic [BCW-1:0]        r_burst_cnt;
  logic                  r_last_ok;
  logic [TOW-1:0]        r_to_cnt;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [IDW-1:0]        r_grant_id;
  logic                  r_arb_busy;
  logic                  r_err_timeout;

  logic                  w_hold;
  logic [IDW-1:0]        w_start;
  logic                  w_found;
  logic [IDW-1:0]        w_winner;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic [NUM_REQ-1:0]    w_ready_vec;
  logic                  w_accept;
  int                    w_idx;

  function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  // Burst continuation only after a clean frame and while the last winner still has data.
  assign w_hold  = r_last_ok && (int'(r_burst_cnt) < MAX_BURST - 1) && i_req_valid[r_grant_id];
  assign w_start = w_hold ? r_grant_id : r_rr_ptr;

  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_win_data  = '0;
    w_ready_vec = '0;
    w_idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(w_start) + k) % NUM_REQ;
      if (!w_found && i_req_valid[w_idx]) begin
        w_found            = 1'b1;
        w_winner           = IDW'(w_idx);
        w_win_data         = i_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
        w_ready_vec[w_idx] = 1'b1;
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && !i_reset && w_found;
  assign o_req_ready = w_accept ? w_ready_vec : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_burst_cnt   <= '0;
      r_last_ok     <= 1'b0;
      r_to_cnt      <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_arb_busy    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_data  <= w_win_data;
            r_grant_id <= w_winner;
            if (w_hold) begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
              r_burst_cnt <= '0;
              r_rr_ptr    <= f_inc(w_winner);
            end
            r_tx_start <= 1'b1;
            r_arb_busy <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
            r_err_timeout <= 1'b1;
            r_burst_cnt   <= '0;
            r_rr_ptr      <= f_inc(r_grant_id);
            r_last_ok     <= 1'b0;
            r_arb_busy    <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            r_last_ok  <= 1'b1;
            r_arb_busy <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_grant_id    = r_grant_id;
  assign o_arb_busy    = r_arb_busy;
  assign o_err_timeout = r_err_timeout;

endmodule
